// File: rtl/trisc_pkg.sv
`default_nettype none
// ============================================================================
// trisc_pkg : shared widths, fetch FSM states and opcode names for TRISC
// Revision  : 1.0 - initial release
// ============================================================================
package trisc_pkg;

  localparam int OPC_W  = 5;
  localparam int OP_W   = 11;
  localparam int INSN_W = 16;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_DONE = 2'd2
  } fetch_state_e;

  localparam logic [OPC_W-1:0] OPC_NOP = 5'd0;
  localparam logic [OPC_W-1:0] OPC_LDI = 5'd1;
  localparam logic [OPC_W-1:0] OPC_LD  = 5'd2;
  localparam logic [OPC_W-1:0] OPC_ST  = 5'd3;
  localparam logic [OPC_W-1:0] OPC_ADD = 5'd4;
  localparam logic [OPC_W-1:0] OPC_SUB = 5'd5;
  localparam logic [OPC_W-1:0] OPC_AND = 5'd6;
  localparam logic [OPC_W-1:0] OPC_OR  = 5'd7;
  localparam logic [OPC_W-1:0] OPC_XOR = 5'd8;
  localparam logic [OPC_W-1:0] OPC_JMP = 5'd9;
  localparam logic [OPC_W-1:0] OPC_BZ  = 5'd10;

endpackage
`default_nettype wire

// File: rtl/trisc_op_decode.sv
`default_nettype none
// ============================================================================
// trisc_op_decode : combinational one-hot opcode and field decode of IR
// Revision        : 1.0 - initial release
// ============================================================================
module trisc_op_decode
  import trisc_pkg::*;
(
  input  logic [INSN_W-1:0] ir,
  output logic [OP_W-1:0]   op,
  output logic [2:0]        ra,
  output logic [2:0]        rb,
  output logic [7:0]        imm,
  output logic              illegal
);

  logic [OPC_W-1:0] opcode;

  assign opcode = ir[15:11];
  assign ra     = ir[10:8];
  assign rb     = ir[7:5];
  assign imm    = ir[7:0];

  // Opcodes beyond the last named one have no op line and are flagged.
  always_comb begin
    op      = '0;
    illegal = 1'b1;
    if (opcode <= OPC_BZ) begin
      op      = OP_W'(1) << opcode;
      illegal = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/trisc_fetch_decode.sv
`default_nettype none
// ============================================================================
// trisc_fetch_decode : PC, instruction fetch FSM with ack timeout, and decode
// Revision           : 1.0 - initial release
// ============================================================================
module trisc_fetch_decode
  import trisc_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              ir_ld,
  input  logic              pc_inc,
  input  logic              pc_ld,
  input  logic [ADDR_W-1:0] pc_target,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [OP_W-1:0]   op,
  output logic [2:0]        ra,
  output logic [2:0]        rb,
  output logic [7:0]        imm,
  output logic              busy,
  output logic              fetch_done,
  output logic              illegal,
  output logic              fetch_err
);

  localparam int                CNT_W   = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(ACK_TIMEOUT - 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INSN_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fetch_err_q, fetch_err_d;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q     <= F_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      cnt_q       <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      cnt_q       <= cnt_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    cnt_d       = cnt_q;
    fetch_err_d = fetch_err_q;

    case (state_q)
      F_IDLE: begin
        if (ir_ld) begin
          state_d = F_REQ;
          cnt_d   = '0;
        end
      end
      F_REQ: begin
        // An ack on the final waiting cycle still wins over the timeout.
        if (mem_ack) begin
          ir_d    = mem_rdata;
          state_d = F_DONE;
        end else if (cnt_q == TO_LAST) begin
          fetch_err_d = 1'b1;
          state_d     = F_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      F_DONE:  state_d = F_IDLE;
      default: state_d = F_IDLE;
    endcase

    // PC is frozen while a request is outstanding so mem_addr cannot move.
    if (state_q != F_REQ) begin
      if (pc_ld) begin
        pc_d = pc_target;
      end else if (pc_inc) begin
        pc_d = pc_q + ADDR_W'(1);
      end
    end
  end

  assign mem_req    = (state_q == F_REQ);
  assign busy       = (state_q != F_IDLE);
  assign fetch_done = (state_q == F_DONE);
  assign mem_addr   = pc_q;
  assign fetch_err  = fetch_err_q;

  trisc_op_decode u_op_decode (
    .ir      (ir_q),
    .op      (op),
    .ra      (ra),
    .rb      (rb),
    .imm     (imm),
    .illegal (illegal)
  );

endmodule
`default_nettype wire
